// File: rtl/ga_pkg.sv
// Shared state encoding and population-source codes for the GA phase sequencer.
package ga_pkg;

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_INIT_GO   = 4'd1,
        S_INIT_WAIT = 4'd2,
        S_SEL_GO    = 4'd3,
        S_SEL_WAIT  = 4'd4,
        S_MUT_GO    = 4'd5,
        S_MUT_WAIT  = 4'd6,
        S_CHECK     = 4'd7,
        S_DONE      = 4'd8
    } ga_state_t;

    localparam logic POP_SRC_INIT = 1'b0;
    localparam logic POP_SRC_MUT  = 1'b1;

endpackage

// File: rtl/ga_phase_watchdog.sv
// Per-phase cycle watchdog: cleared on each phase launch, counts while waiting for the phase to finish.
module ga_phase_watchdog #(
    parameter logic [31:0] TMO_CYCLES = 32'd1000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic count_en,
    output logic expired
);

    logic [31:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n)
            cnt <= '0;
        else if (clear)
            cnt <= '0;
        else if (count_en && cnt != '1)
            cnt <= cnt + 32'd1;
    end

    // Fires on the wait cycle that would be the TMO_CYCLES-th one.
    assign expired = count_en && (({1'b0, cnt} + 33'd1) >= {1'b0, TMO_CYCLES});

endmodule

// File: rtl/ga_phase_sequencer.sv
// Phase controller for the GA brew-run engine: init -> (select -> mutate -> check)* -> done.
// Optional per-phase watchdog enabled by defining GA_PHASE_TIMEOUT_EN.
module ga_phase_sequencer
    import ga_pkg::*;
#(
    parameter int                GEN_W      = 16,
    parameter logic [GEN_W-1:0]  MAX_GEN    = GEN_W'(100),
    parameter logic [31:0]       TMO_CYCLES = 32'd1000000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic             init_done,
    input  logic             sel_done,
    input  logic             mut_done,
    input  logic             fitness_hit,
    output logic             init_start,
    output logic             sel_start,
    output logic             mut_start,
    output logic             pop_sel,
    output logic [GEN_W-1:0] gen_count,
    output logic             busy,
    output logic             done,
    output logic             timeout_err
);

    ga_state_t        state, state_nxt;
    logic [GEN_W-1:0] gen_inc, max_eff;
    logic             wd_expired;

    assign max_eff = (MAX_GEN == '0) ? GEN_W'(1) : MAX_GEN;
    assign gen_inc = (&gen_count) ? gen_count : gen_count + GEN_W'(1);

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_DONE: if (start)       state_nxt = S_INIT_GO;
            S_INIT_GO:                       state_nxt = S_INIT_WAIT;
            S_INIT_WAIT:    if (init_done)   state_nxt = S_SEL_GO;
            S_SEL_GO:                        state_nxt = S_SEL_WAIT;
            S_SEL_WAIT:     if (sel_done)    state_nxt = S_MUT_GO;
            S_MUT_GO:                        state_nxt = S_MUT_WAIT;
            S_MUT_WAIT:     if (mut_done)    state_nxt = S_CHECK;
            S_CHECK:        state_nxt = (fitness_hit || gen_inc >= max_eff) ? S_DONE : S_SEL_GO;
            default:                         state_nxt = S_IDLE;
        endcase
        // Abort and watchdog expiry override every other transition.
        if ((abort && state != S_IDLE) || wd_expired)
            state_nxt = S_IDLE;
    end

    // Outputs are registered from the state being entered, so strobes line up with *_GO.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            init_start <= 1'b0;
            sel_start  <= 1'b0;
            mut_start  <= 1'b0;
            pop_sel    <= POP_SRC_INIT;
            gen_count  <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_nxt;
            init_start <= (state_nxt == S_INIT_GO);
            sel_start  <= (state_nxt == S_SEL_GO);
            mut_start  <= (state_nxt == S_MUT_GO);
            busy       <= !(state_nxt inside {S_IDLE, S_DONE});
            done       <= (state_nxt == S_DONE);
            if (state_nxt == S_INIT_GO) begin
                gen_count <= '0;
                pop_sel   <= POP_SRC_INIT;
            end else if (state == S_CHECK && state_nxt != S_IDLE) begin
                gen_count <= gen_inc;
                pop_sel   <= POP_SRC_MUT;
            end
        end
    end

`ifdef GA_PHASE_TIMEOUT_EN
    ga_phase_watchdog #(.TMO_CYCLES(TMO_CYCLES)) u_watchdog (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (state inside {S_INIT_GO, S_SEL_GO, S_MUT_GO}),
        .count_en (state inside {S_INIT_WAIT, S_SEL_WAIT, S_MUT_WAIT}),
        .expired  (wd_expired)
    );

    always_ff @(posedge clk) begin
        if (!rst_n)
            timeout_err <= 1'b0;
        else if (state_nxt == S_INIT_GO)
            timeout_err <= 1'b0;
        else if (wd_expired)
            timeout_err <= 1'b1;
    end
`else
    // Without the watchdog the limit is inert; WAIT states hold indefinitely.
    assign wd_expired  = 1'b0 && (TMO_CYCLES != 32'd0);
    assign timeout_err = 1'b0;
`endif

endmodule
